rx_cpu_dir_ctrl: RTL

RX_CPU_DIR_CTRL -- requirements
Module: rx_cpu_dir_ctrl

---
 rtl/xge_rx_pkg.sv | 18 +
 rtl/rx_cpu_token_bucket.sv | 63 ++++++
 rtl/rx_cpu_dir_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/xge_rx_pkg.sv
// xge_rx: shared definitions for the RX direction path.
//   RX_DIR_CNT        width of the committed direction vector
//   RX_DIR_DROP       bit index of the drop direction
//   RX_DIR_CPU        bit index of the CPU direction
//   cpu_dir_state_e   state type of the CPU direction controller
package xge_rx;

    localparam int unsigned RX_DIR_CNT  = 4;
    localparam int unsigned RX_DIR_DROP = 0;
    localparam int unsigned RX_DIR_CPU  = 1;

    typedef enum logic [1:0] {
        CpuDirDisabled = 2'd0,
        CpuDirRun      = 2'd1,
        CpuDirDrain    = 2'd2
    } cpu_dir_state_e;

endpackage

// File: rtl/rx_cpu_token_bucket.sv
// rx_cpu_token_bucket: refill timer and token counter that rate-limit the CPU direction.
//   clk_i              system clock
//   rst_n_i            synchronous active-low reset
//   cfg_rate_period_i  cycles per token refill, 0 disables rate limiting
//   cfg_burst_i        token ceiling
//   consume_i          one packet committed toward the CPU this cycle
//   tok_cnt_o          current token count
//   tok_next_o         token count after this edge (feeds the write-allowed register)
module rx_cpu_token_bucket #(
    parameter int unsigned TOK_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [15:0]      cfg_rate_period_i,
    input  logic [TOK_W-1:0] cfg_burst_i,
    input  logic             consume_i,
    output logic [TOK_W-1:0] tok_cnt_o,
    output logic [TOK_W-1:0] tok_next_o
);

    logic [15:0]      timer_q, timer_d;
    logic [TOK_W-1:0] tok_q, tok_d, tok_base;
    logic             rate_on;
    logic             refill;
    logic             consume;

    assign rate_on = (cfg_rate_period_i != 16'd0);
    // ">=" so that shrinking the period mid-count still wraps instead of running to 2^16
    assign refill  = rate_on && (timer_q >= (cfg_rate_period_i - 16'd1));
    assign consume = consume_i && rate_on;

    always_comb begin
        timer_d = timer_q + 16'd1;
        if (!rate_on || refill) begin
            timer_d = 16'd0;
        end
    end

    always_comb begin
        tok_base = tok_q;
        if (refill && !consume && (tok_q < cfg_burst_i)) begin
            tok_base = tok_q + TOK_W'(1);
        end else if (consume && !refill && (tok_q != '0)) begin
            tok_base = tok_q - TOK_W'(1);
        end
        // Clamp also covers a burst ceiling lowered below the current count
        tok_d = (tok_base > cfg_burst_i) ? cfg_burst_i : tok_base;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            timer_q <= 16'd0;
            tok_q   <= '0;
        end else begin
            timer_q <= timer_d;
            tok_q   <= tok_d;
        end
    end

    assign tok_cnt_o  = tok_q;
    assign tok_next_o = tok_d;

endmodule

// File: rtl/rx_cpu_dir_ctrl.sv
// rx_cpu_dir_ctrl: gates the CPU direction of the RX resolver on enable, outstanding
// packets and a token-bucket rate limit; counts drops and flags stray CPU releases.
//   clk_i / rst_n_i     clock and synchronous active-low reset
//   cfg_en_i            CPU direction enable
//   cfg_max_pend_i      limit on packets outstanding toward the CPU
//   cfg_rate_period_i   cycles per token refill, 0 = unlimited
//   cfg_burst_i         token ceiling
//   dir_commit_i        resolver decision strobe, qualifies rx_dir_i
//   rx_dir_i            committed direction vector
//   cpu_pkt_done_i      CPU released one packet
//   cnt_clr_i           clears drop_cnt_o and err_o
//   dir_cpu_wa_o        CPU write-allowed
//   pend_cnt_o          packets outstanding toward the CPU
//   tok_cnt_o           current token count
//   drop_cnt_o          saturating drop-commit count
//   err_o               sticky: release seen with nothing outstanding
module rx_cpu_dir_ctrl
    import xge_rx::*;
#(
    parameter int unsigned DIR_CNT = xge_rx::RX_DIR_CNT,
    parameter int unsigned PEND_W  = 8,
    parameter int unsigned TOK_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cfg_en_i,
    input  logic [PEND_W-1:0]  cfg_max_pend_i,
    input  logic [15:0]        cfg_rate_period_i,
    input  logic [TOK_W-1:0]   cfg_burst_i,
    input  logic               dir_commit_i,
    input  logic [DIR_CNT-1:0] rx_dir_i,
    input  logic               cpu_pkt_done_i,
    input  logic               cnt_clr_i,
    output logic               dir_cpu_wa_o,
    output logic [PEND_W-1:0]  pend_cnt_o,
    output logic [TOK_W-1:0]   tok_cnt_o,
    output logic [31:0]        drop_cnt_o,
    output logic               err_o
);

    cpu_dir_state_e    state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [31:0]       drop_q, drop_d;
    logic              err_q, err_d;
    logic              wa_q, wa_d;
    logic [TOK_W-1:0]  tok_next;
    logic              cpu_commit;
    logic              drop_commit;
    logic              unused_dir;

    assign cpu_commit  = dir_commit_i && rx_dir_i[RX_DIR_CPU];
    assign drop_commit = dir_commit_i && rx_dir_i[RX_DIR_DROP];
    assign unused_dir  = ^rx_dir_i;

    rx_cpu_token_bucket #(
        .TOK_W (TOK_W)
    ) u_bucket (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .cfg_rate_period_i (cfg_rate_period_i),
        .cfg_burst_i       (cfg_burst_i),
        .consume_i         (cpu_commit),
        .tok_cnt_o         (tok_cnt_o),
        .tok_next_o        (tok_next)
    );

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= CpuDirDisabled;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CpuDirDisabled: if (cfg_en_i) state_d = CpuDirRun;
            CpuDirRun:      if (!cfg_en_i) state_d = CpuDirDrain;
            CpuDirDrain: begin
                if (cfg_en_i) begin
                    state_d = CpuDirRun;
                end else if (pend_q == '0) begin
                    state_d = CpuDirDisabled;
                end
            end
            default:        state_d = CpuDirDisabled;
        endcase
    end

    // FSM: output, registered so every cause reaches dir_cpu_wa_o one cycle later
    always_comb begin
        wa_d = (state_d == CpuDirRun) && (pend_d < cfg_max_pend_i) &&
               ((tok_next != '0) || (cfg_rate_period_i == 16'd0));
    end

    // Commits are accounted regardless of wa, since the resolver may already be committed.
    always_comb begin
        pend_d = pend_q;
        if (cpu_commit && !cpu_pkt_done_i) begin
            if (pend_q != '1) begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (cpu_pkt_done_i && !cpu_commit) begin
            if (pend_q != '0) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end
    end

    // A release paired with a same-cycle commit is balanced, so it is not an error.
    always_comb begin
        err_d = err_q;
        if (cnt_clr_i) begin
            err_d = 1'b0;
        end else if (cpu_pkt_done_i && !cpu_commit && (pend_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (cnt_clr_i) begin
            drop_d = 32'd0;
        end else if (drop_commit && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            drop_q <= 32'd0;
            err_q  <= 1'b0;
            wa_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            err_q  <= err_d;
            wa_q   <= wa_d;
        end
    end

    assign dir_cpu_wa_o = wa_q;
    assign pend_cnt_o   = pend_q;
    assign drop_cnt_o   = drop_q;
    assign err_o        = err_q;

endmodule
